// File: rtl/code_wp_pkg.sv
// Shared definitions for the code write-protect controller and the code guard.
package code_wp_pkg;

   // Controller FSM states; the encoding is visible on state_o for debug.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_SEALED = 2'd3
   } wp_state_e;

   // Boot ROM command opcodes.
   typedef enum logic [1:0] {
      OP_KEY    = 2'd0,
      OP_CLOSE  = 2'd1,
      OP_SET_WP = 2'd2,
      OP_LOCK   = 2'd3
   } wp_op_e;

   localparam logic [31:0] DEF_KEY0 = 32'hC0DE_5EED;
   localparam logic [31:0] DEF_KEY1 = 32'h5A5A_A5A5;

   // Width of the update-window down-counter.
   localparam int unsigned WIN_W = 24;

endpackage

// File: rtl/code_update_ctrl_if.sv
// Boot ROM command strobe bus into the code-update controller.
interface code_update_ctrl_if;
   import code_wp_pkg::*;

   logic        cmd_valid;
   wp_op_e      cmd_op;
   logic [31:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data);
   modport slave  (input  cmd_valid, input  cmd_op, input  cmd_data);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with registered output.
module sat_counter #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned MAX   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // Increment on request, holding once the ceiling is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/code_update_ctrl.sv
// Two-key armed code-update window; write-protect and lock latch once it
// closes and hold until reset.
module code_update_ctrl
   import code_wp_pkg::*;
#(
   parameter logic [31:0] KEY0          = DEF_KEY0,
   parameter logic [31:0] KEY1          = DEF_KEY1,
   parameter int unsigned ARM_GAP       = 16,
   parameter int unsigned WINDOW_CYCLES = 65535,
   parameter int unsigned MAX_FAILS     = 3
) (
   input  logic               clk,
   input  logic               rst,
   code_update_ctrl_if.slave  cmd,
   output logic               update_en,
   output logic               wp_q,
   output logic               lock_o,
   output logic [1:0]         state_o,
   output logic               timeout_evt,
   output logic               key_fail,
   output logic [1:0]         fail_cnt
);
   localparam int unsigned      GAP_W     = $clog2(ARM_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(ARM_GAP);
   localparam logic [WIN_W-1:0] WIN_LOAD  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [1:0]       FAIL_MAX  = 2'(MAX_FAILS);

   wp_state_e        state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic             update_en_q, update_en_d;
   logic             wp_d;
   logic             lock_q, lock_d;
   logic             timeout_q, timeout_d;
   logic             key_fail_q, fail_d;

   logic is_key, is_close, is_set_wp, is_lock, is_shut, fail_max;

   assign is_key    = cmd.cmd_valid && (cmd.cmd_op == OP_KEY);
   assign is_close  = cmd.cmd_valid && (cmd.cmd_op == OP_CLOSE);
   assign is_set_wp = cmd.cmd_valid && (cmd.cmd_op == OP_SET_WP);
   assign is_lock   = cmd.cmd_valid && (cmd.cmd_op == OP_LOCK);
   assign is_shut   = is_close || is_set_wp;
   assign fail_max  = (fail_cnt == FAIL_MAX);

   // Next-state and next-output decode; commands beat gap/window expiry
   // except that gap expiry beats a late KEY1.
   always_comb begin
      // NOTE: every target gets a default before the case so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      gap_d     = gap_q;
      win_d     = win_q;
      wp_d      = wp_q;
      lock_d    = lock_q;
      timeout_d = 1'b0;
      fail_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (is_key) begin
               // Arming is refused while protected or once the lockout is due.
               if ((cmd.cmd_data == KEY0) && !wp_q && !fail_max) begin
                  state_d = ST_ARMED;
                  gap_d   = '0;
               end else begin
                  fail_d = 1'b1;
               end
            end else if (is_set_wp) begin
               wp_d = 1'b1;
            end else if (is_lock) begin
               state_d = ST_SEALED;
            end
         end
         ST_ARMED: begin
            gap_d = gap_q + 1'b1;
            if (is_lock) begin
               state_d = ST_SEALED;
            end else if (is_shut) begin
               wp_d    = 1'b1;
               state_d = ST_IDLE;
            end else if (gap_q == GAP_LIMIT) begin
               fail_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (is_key) begin
               if (cmd.cmd_data == KEY1) begin
                  state_d = ST_UPDATE;
                  win_d   = WIN_LOAD;
               end else begin
                  fail_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_UPDATE: begin
            win_d = win_q - 1'b1;
            if (is_lock) begin
               state_d = ST_SEALED;
            end else if (is_shut) begin
               wp_d    = 1'b1;
               state_d = ST_IDLE;
            end else if (win_q == '0) begin
               wp_d      = 1'b1;
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_SEALED: ;
      endcase

      // Entering SEALED raises lock and write-protect together.
      if (state_d == ST_SEALED) begin
         lock_d = 1'b1;
         wp_d   = 1'b1;
      end
      // Lockout forces protection the cycle after the count saturates.
      if (fail_max) wp_d = 1'b1;

      update_en_d = (state_d == ST_UPDATE);
   end

   // State and registered outputs; reset clears any open window at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gap_q       <= '0;
         win_q       <= '0;
         update_en_q <= 1'b0;
         wp_q        <= 1'b0;
         lock_q      <= 1'b0;
         timeout_q   <= 1'b0;
         key_fail_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q     <= state_d;
         gap_q       <= gap_d;
         win_q       <= win_d;
         update_en_q <= update_en_d;
         wp_q        <= wp_d;
         lock_q      <= lock_d;
         timeout_q   <= timeout_d;
         key_fail_q  <= fail_d;
      end
   end

   sat_counter #(
      .WIDTH (2),
      .MAX   (MAX_FAILS)
   ) u_fail_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (fail_d),
      .cnt_o (fail_cnt)
   );

   assign update_en   = update_en_q;
   assign lock_o      = lock_q;
   assign state_o     = state_q;
   assign timeout_evt = timeout_q;
   assign key_fail    = key_fail_q;
endmodule

// File: tb/tb_code_update_ctrl.sv
// Bench for code_update_ctrl: a full-size instance for the 65535-cycle
// window and a short-window instance for directed, table and random tests.
module tb_code_update_ctrl;
   import code_wp_pkg::*;

   localparam int          GAP   = 16;
   localparam int          WIN_S = 150;
   localparam int          MAXF  = 3;
   localparam logic [31:0] K0    = 32'hC0DE_5EED;
   localparam logic [31:0] K1    = 32'h5A5A_A5A5;

   localparam int PH_IDLE = 0, PH_ARMED = 1, PH_OPEN = 2, PH_SEALED = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   code_update_ctrl_if bus();
   code_update_ctrl_if bus_b();

   logic       s_ue, s_wp, s_lk, s_to, s_kf;
   logic [1:0] s_st, s_fc;
   logic       b_ue, b_wp, b_lk, b_to, b_kf;
   logic [1:0] b_st, b_fc;

   code_update_ctrl #(.WINDOW_CYCLES(WIN_S)) dut (
      .clk(clk), .rst(rst), .cmd(bus),
      .update_en(s_ue), .wp_q(s_wp), .lock_o(s_lk), .state_o(s_st),
      .timeout_evt(s_to), .key_fail(s_kf), .fail_cnt(s_fc)
   );

   code_update_ctrl dut_big (
      .clk(clk), .rst(rst), .cmd(bus_b),
      .update_en(b_ue), .wp_q(b_wp), .lock_o(b_lk), .state_o(b_st),
      .timeout_evt(b_to), .key_fail(b_kf), .fail_cnt(b_fc)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: phase plus timestamps of arming and window opening.
   int     m_phase, m_fails;
   longint m_now, m_armed_at, m_opened_at;
   bit     m_wp, m_lock, m_ue, m_to, m_kf;

   task automatic model_reset();
      m_phase = PH_IDLE; m_fails = 0; m_now = 0; m_armed_at = 0; m_opened_at = 0;
      m_wp = 0; m_lock = 0; m_ue = 0; m_to = 0; m_kf = 0;
   endtask

   task automatic model_seal();
      m_phase = PH_SEALED; m_lock = 1; m_wp = 1;
   endtask

   task automatic model_step(input bit v, input wp_op_e op, input logic [31:0] d);
      bit fail, forced;
      fail   = 0;
      forced = (m_fails == MAXF);
      m_to   = 0;
      m_kf   = 0;
      m_now++;
      case (m_phase)
         PH_IDLE: if (v) begin
            if (op == OP_KEY) begin
               if (d == K0 && !m_wp && m_fails < MAXF) begin
                  m_phase = PH_ARMED; m_armed_at = m_now;
               end else fail = 1;
            end else if (op == OP_SET_WP) m_wp = 1;
            else if (op == OP_LOCK) model_seal();
         end
         PH_ARMED: begin
            if (v && op == OP_LOCK) model_seal();
            else if (v && (op == OP_CLOSE || op == OP_SET_WP)) begin
               m_wp = 1; m_phase = PH_IDLE;
            end else if (m_now - m_armed_at > GAP) begin
               fail = 1; m_phase = PH_IDLE;
            end else if (v && op == OP_KEY) begin
               if (d == K1) begin
                  m_phase = PH_OPEN; m_opened_at = m_now;
               end else begin
                  fail = 1; m_phase = PH_IDLE;
               end
            end
         end
         PH_OPEN: begin
            if (v && op == OP_LOCK) model_seal();
            else if (v && (op == OP_CLOSE || op == OP_SET_WP)) begin
               m_wp = 1; m_phase = PH_IDLE;
            end else if (m_now - m_opened_at >= WIN_S) begin
               m_wp = 1; m_to = 1; m_phase = PH_IDLE;
            end
         end
         default: ;
      endcase
      if (forced) m_wp = 1;
      if (fail) begin
         m_kf = 1;
         if (m_fails < MAXF) m_fails++;
      end
      m_ue = (m_phase == PH_OPEN);
   endtask

   task automatic check_model(input string tag);
      check({tag, " update_en"},   s_ue, m_ue);
      check({tag, " wp_q"},        s_wp, m_wp);
      check({tag, " lock_o"},      s_lk, m_lock);
      check({tag, " state_o"},     s_st, m_phase);
      check({tag, " timeout_evt"}, s_to, m_to);
      check({tag, " key_fail"},    s_kf, m_kf);
      check({tag, " fail_cnt"},    s_fc, m_fails);
   endtask

   // One clock on the short-window DUT; inputs change 1 time unit after an edge.
   task automatic cycle(input bit v, input wp_op_e op, input logic [31:0] d, input string tag);
      bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_data = d;
      model_step(v, op, d);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check_model(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) cycle(1'b0, OP_KEY, 32'h0, tag);
   endtask

   task automatic cycle_b(input bit v, input wp_op_e op, input logic [31:0] d);
      bus_b.cmd_valid = v; bus_b.cmd_op = op; bus_b.cmd_data = d;
      @(posedge clk); #1;
      bus_b.cmd_valid = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk); #1;
      check({tag, " reset outputs"}, {s_ue, s_wp, s_lk, s_st, s_to, s_kf, s_fc}, 0);
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit          v;
      wp_op_e      op;
      logic [31:0] d;
      bit          ue, wp, lk;
      logic [1:0]  st;
      bit          to, kf;
      logic [1:0]  fc;
   } vec_t;

   vec_t tbl[14];

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int count;
      bus.cmd_valid = 1'b0; bus.cmd_op = OP_KEY; bus.cmd_data = '0;
      bus_b.cmd_valid = 1'b0; bus_b.cmd_op = OP_KEY; bus_b.cmd_data = '0;
      model_reset();

      //                v  op         data           ue wp lk st  to kf fc
      tbl[0]  = '{1'b0, OP_CLOSE,  32'h0,         0, 0, 0, 2'd0, 0, 0, 2'd0};
      tbl[1]  = '{1'b1, OP_KEY,    32'hDEAD_BEEF, 0, 0, 0, 2'd0, 0, 1, 2'd1};
      tbl[2]  = '{1'b1, OP_CLOSE,  32'h0,         0, 0, 0, 2'd0, 0, 0, 2'd1};
      tbl[3]  = '{1'b1, OP_KEY,    K0,            0, 0, 0, 2'd1, 0, 0, 2'd1};
      tbl[4]  = '{1'b1, OP_KEY,    32'h0000_1234, 0, 0, 0, 2'd0, 0, 1, 2'd2};
      tbl[5]  = '{1'b1, OP_KEY,    K0,            0, 0, 0, 2'd1, 0, 0, 2'd2};
      tbl[6]  = '{1'b1, OP_KEY,    K1,            1, 0, 0, 2'd2, 0, 0, 2'd2};
      tbl[7]  = '{1'b1, OP_KEY,    32'hFFFF_FFFF, 1, 0, 0, 2'd2, 0, 0, 2'd2};
      tbl[8]  = '{1'b1, OP_SET_WP, 32'h0,         0, 1, 0, 2'd0, 0, 0, 2'd2};
      tbl[9]  = '{1'b1, OP_KEY,    K0,            0, 1, 0, 2'd0, 0, 1, 2'd3};
      tbl[10] = '{1'b0, OP_KEY,    32'h0,         0, 1, 0, 2'd0, 0, 0, 2'd3};
      tbl[11] = '{1'b1, OP_KEY,    K0,            0, 1, 0, 2'd0, 0, 1, 2'd3};
      tbl[12] = '{1'b1, OP_LOCK,   32'h0,         0, 1, 1, 2'd3, 0, 0, 2'd3};
      tbl[13] = '{1'b1, OP_KEY,    32'h1111_2222, 0, 1, 1, 2'd3, 0, 0, 2'd3};

      // Full-size window: KEY0, KEY1 two cycles later, count update_en cycles.
      do_reset("big");
      check("big reset outputs", {b_ue, b_wp, b_lk, b_st, b_to, b_kf, b_fc}, 0);
      cycle_b(1'b1, OP_KEY, K0);
      cycle_b(1'b0, OP_KEY, 32'h0);
      cycle_b(1'b1, OP_KEY, K1);
      check("big update_en rises", b_ue, 1);
      count = 1;
      while (b_ue && count < 70000) begin
         @(posedge clk); #1;
         if (b_ue) count++;
      end
      check("big window length", count, 65535);
      check("big timeout_evt", b_to, 1);
      check("big wp_q after timeout", b_wp, 1);
      check("big state_o after timeout", b_st, 0);
      cycle_b(1'b0, OP_KEY, 32'h0);
      check("big timeout_evt one cycle", b_to, 0);

      // Table-driven sequence from reset.
      do_reset("tbl");
      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].v, tbl[i].op, tbl[i].d, "tbl model");
         check($sformatf("tbl[%0d] {ue,wp,lk,st,to,kf,fc}", i),
               {s_ue, s_wp, s_lk, s_st, s_to, s_kf, s_fc},
               {tbl[i].ue, tbl[i].wp, tbl[i].lk, tbl[i].st, tbl[i].to, tbl[i].kf, tbl[i].fc});
      end

      // Bad-key lockout.
      do_reset("lockout");
      for (int i = 0; i < 3; i++) cycle(1'b1, OP_KEY, 32'hDEAD_BEEF, "lockout bad");
      check("lockout fail_cnt", s_fc, 3);
      idle(1, "lockout");
      check("lockout wp_q forced", s_wp, 1);
      cycle(1'b1, OP_KEY, K0, "lockout k0");
      cycle(1'b1, OP_KEY, K1, "lockout k1");
      check("lockout update_en stays 0", s_ue, 0);

      // Gap boundary: KEY1 on the last allowed cycle opens the window.
      do_reset("gap ok");
      cycle(1'b1, OP_KEY, K0, "gap ok k0");
      idle(GAP - 1, "gap ok wait");
      cycle(1'b1, OP_KEY, K1, "gap ok k1");
      check("gap ok state_o", s_st, 2);

      // Gap expiry beats a same-cycle KEY1.
      do_reset("gap exp");
      cycle(1'b1, OP_KEY, K0, "gap exp k0");
      idle(GAP, "gap exp wait");
      cycle(1'b1, OP_KEY, K1, "gap exp k1");
      check("gap exp key_fail", s_kf, 1);
      check("gap exp state_o", s_st, 0);
      check("gap exp update_en", s_ue, 0);

      // Early close after 100 window cycles.
      do_reset("close");
      cycle(1'b1, OP_KEY, K0, "close k0");
      cycle(1'b1, OP_KEY, K1, "close k1");
      idle(99, "close window");
      cycle(1'b1, OP_CLOSE, 32'h0, "close cmd");
      check("close update_en", s_ue, 0);
      check("close wp_q", s_wp, 1);
      cycle(1'b1, OP_KEY, K0, "close rekey");
      check("close rekey key_fail", s_kf, 1);

      // Short-window natural timeout.
      do_reset("timeout");
      cycle(1'b1, OP_KEY, K0, "timeout k0");
      cycle(1'b1, OP_KEY, K1, "timeout k1");
      idle(WIN_S - 1, "timeout window");
      check("timeout ue last cycle", s_ue, 1);
      idle(1, "timeout expiry");
      check("timeout timeout_evt", s_to, 1);
      check("timeout wp_q", s_wp, 1);
      idle(1, "timeout after");

      // LOCK in the exact expiry cycle wins over the timeout.
      do_reset("race");
      cycle(1'b1, OP_KEY, K0, "race k0");
      cycle(1'b1, OP_KEY, K1, "race k1");
      idle(WIN_S - 1, "race window");
      cycle(1'b1, OP_LOCK, 32'h0, "race lock");
      check("race state_o", s_st, 3);
      check("race lock_o", s_lk, 1);
      check("race timeout_evt", s_to, 0);
      cycle(1'b1, OP_KEY, K0, "race sealed key");
      cycle(1'b1, OP_CLOSE, 32'h0, "race sealed close");
      cycle(1'b1, OP_KEY, 32'h0BAD_0BAD, "race sealed bad");
      check("race sealed no pulses", {s_to, s_kf}, 0);

      // Asynchronous reset in the middle of an open window.
      do_reset("midrst");
      cycle(1'b1, OP_KEY, K0, "midrst k0");
      cycle(1'b1, OP_KEY, K1, "midrst k1");
      idle(20, "midrst window");
      rst = 1'b1;
      #1;
      check("midrst async clear", {s_ue, s_wp, s_lk, s_st, s_to, s_kf, s_fc}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cycle(1'b1, OP_KEY, K0, "midrst rekey k0");
      cycle(1'b1, OP_KEY, K1, "midrst rekey k1");
      check("midrst reopened", s_ue, 1);

      // Randomized traffic against the model, with periodic resets.
      do_reset("rand");
      for (int i = 0; i < 4000; i++) begin
         bit          v;
         wp_op_e      op;
         logic [31:0] d;
         int          r;
         if (i % 500 == 499) do_reset("rand");
         v = ($urandom_range(0, 99) < 12);
         r = $urandom_range(0, 99);
         op = (r < 80) ? OP_KEY : (r < 88) ? OP_CLOSE : (r < 97) ? OP_SET_WP : OP_LOCK;
         r = $urandom_range(0, 99);
         if (r < 10) d = $urandom;
         else if (r < 85) d = (m_phase == PH_ARMED) ? K1 : K0;
         else d = (m_phase == PH_ARMED) ? K0 : K1;
         cycle(v, op, d, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/code_update_ctrl.md
# code_update_ctrl

Sequential controller that generates the code write-protect controls: `update_en`, sticky `wp_q` and sticky `lock_o`. It sits directly upstream of the code-region write guard. The Boot ROM drives it through a single-cycle command strobe. A two-key arming sequence opens a bounded code-update window. When the window closes, write-protect latches and stays set until reset.

## Interface
Parameters:
- `KEY0`, 32'hC0DE_5EED: first arming key.
- `KEY1`, 32'h5A5A_A5A5: second arming key.
- `ARM_GAP`, 16: maximum cycles allowed between KEY0 and KEY1.
- `WINDOW_CYCLES`, 65535: length of the update window (1..2^24-1).
- `MAX_FAILS`, 3: bad-key count that forces `wp_q`.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: one-cycle command strobe. No back-pressure; every valid command is consumed in the same cycle.
- `cmd_op` in 2: 0 KEY, 1 CLOSE, 2 SET_WP, 3 LOCK.
- `cmd_data` in 32: key value (used only for KEY).
- `update_en` out 1: pre-lock code-write window open.
- `wp_q` out 1: sticky code write-protect.
- `lock_o` out 1: sticky system LOCK.
- `state_o` out 2: FSM state, for debug.
- `timeout_evt` out 1: one-cycle pulse when the window expires.
- `key_fail` out 1: one-cycle pulse on a rejected key.
- `fail_cnt` out 2: saturating count of bad keys.

## Operation
States: IDLE=0, ARMED=1, UPDATE=2, SEALED=3. All outputs are registered.

- **Reset:** state IDLE; every output 0; all counters 0.
- **IDLE**
  - KEY with data==KEY0 and `wp_q`==0: go to ARMED, clear the gap counter.
  - KEY with any other data, or KEY while `wp_q`==1: pulse `key_fail`, increment `fail_cnt`, stay in IDLE.
  - SET_WP: set `wp_q`.
  - LOCK: go to SEALED.
  - CLOSE: no effect.
- **ARMED**
  - The gap counter increments every cycle.
  - KEY==KEY1 while gap < ARM_GAP: go to UPDATE and load the window counter.
  - Wrong key: pulse `key_fail`, increment `fail_cnt`, go to IDLE.
  - Gap reaches ARM_GAP: pulse `key_fail`, increment `fail_cnt`, go to IDLE. This takes priority over a same-cycle KEY1.
  - CLOSE or SET_WP: set `wp_q`, go to IDLE.
  - LOCK: go to SEALED.
- **UPDATE**
  - `update_en`=1 and the window counter decrements every cycle.
  - CLOSE or SET_WP: clear `update_en`, set `wp_q`, go to IDLE.
  - LOCK: go to SEALED.
  - KEY: ignored; no fail is counted.
  - Counter expiry: clear `update_en`, set `wp_q`, pulse `timeout_evt`, go to IDLE.
  - A command in the expiry cycle wins. `timeout_evt` then stays 0, and the command's effect applies.
- **SEALED:** terminal until reset. `lock_o`=1, `wp_q`=1, `update_en`=0. All commands are ignored and produce no pulses.
- **Bad-key lockout:** `fail_cnt` saturates at 3. The cycle after it reaches MAX_FAILS, `wp_q` is forced to 1 permanently.
- **Invariants:**
  - `update_en` implies `wp_q`==0 and `lock_o`==0.
  - `wp_q` and `lock_o` never fall except on `rst`.
- **Reset mid-window:** all outputs clear asynchronously. No partial window survives reset.

## Timing
- Command at edge N: the state and output effect is visible after edge N (1-cycle latency).
- `update_en` rises the cycle after KEY1 is accepted. It stays high for exactly WINDOW_CYCLES cycles unless closed early.
- `timeout_evt` is high in the first cycle `update_en` is 0 after an expiry, coincident with `wp_q` rising.
- A CLOSE/SET_WP/LOCK drops `update_en` and raises `wp_q`/`lock_o` in the same next cycle, so no glitch window exists.
- `key_fail` and `fail_cnt` update one cycle after the offending command or gap expiry.

## Structure
- Shared package `code_wp_pkg` holds:
  - the state enum `wp_state_e`;
  - the op encoding `wp_op_e` (KEY, CLOSE, SET_WP, LOCK);
  - default key constants.
- The code guard imports the same package.
- The window counter is a 24-bit down-counter. The gap counter is `$clog2(ARM_GAP+1)` bits.
- One sub-module is natural: `sat_counter` (parametrised width and max), used for `fail_cnt`.
- Target size: around 200 RTL lines.

## Test plan
- **Window timeout:** reset, KEY 32'hC0DE5EED, KEY 32'h5A5AA5A5 two cycles later → `update_en`=1 for 65535 cycles, then `timeout_evt` pulses, `wp_q`=1, `state_o`=0.
- **Bad key and lockout:** KEY 32'hDEADBEEF in IDLE → `key_fail` pulse, `fail_cnt`=1. Repeat twice → `fail_cnt`=3 and `wp_q`=1. A subsequent correct KEY0/KEY1 pair → `update_en` stays 0.
- **Gap expiry:** KEY0, wait 16 cycles, then KEY1 → `key_fail` pulses on gap expiry, `state_o`=0, `update_en` stays 0.
- **Early close:** open the window, CLOSE after 100 cycles → `update_en` 0 and `wp_q` 1 on the next cycle. A later KEY0 is rejected with `key_fail`.
- **Command vs. expiry race:** open the window, issue LOCK in the exact expiry cycle → `state_o`=3, `lock_o`=1, `wp_q`=1, `timeout_evt` stays 0. Further commands produce no pulses.
- **Reset mid-window:** assert `rst` asynchronously mid-window → all outputs 0 immediately. After release, the FSM is in IDLE and a fresh key sequence reopens the window.
